imem_loader: RTL and testbench

//   Write-side companion to the instruction memory read port. Accepts a byte

---
 rtl/imem_loader.sv | 150 +++++++++++++++
 tb/tb_imem_loader.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Instruction-memory loader: assembles little-endian 32-bit words from a byte
// stream and writes them to consecutive imem addresses while stalling the core.
module imem_loader #(
   parameter int unsigned DEPTH  = 32,
   parameter int unsigned ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W:0]   num_words,
   input  logic [7:0]        byte_in,
   input  logic              byte_valid,
   output logic              byte_ready,
   output logic              we,
   output logic [ADDR_W-1:0] waddr,
   output logic [31:0]       wdata,
   output logic              busy,
   output logic              cpu_stall,
   output logic              done,
   output logic              err
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [ADDR_W:0]   DEPTH_W  = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);
   localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

   state_t            state;
   state_t            state_nx;
   logic [ADDR_W:0]   count;
   logic [ADDR_W:0]   wcnt;
   logic [1:0]        bcnt;
   logic [23:0]       asm_q;

   logic              hs;
   logic              start_ok;
   logic              n_zero;
   logic              n_big;
   logic              last_word;

   assign start_ok  = start && ((state == IDLE) || (state == DONE));
   assign n_zero    = (num_words == '0);
   assign n_big     = (num_words > DEPTH_W);
   assign hs        = byte_valid && byte_ready;
   assign last_word = ((wcnt + CNT_ONE) == count);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx   = state;
      byte_ready = 1'b0;
      we         = 1'b0;
      busy       = 1'b0;
      unique case (state)
         IDLE, DONE: begin
            if (start_ok) begin
               if (n_big) begin
                  state_nx = IDLE;
               end else if (n_zero) begin
                  state_nx = DONE;
               end else begin
                  state_nx = LOAD;
               end
            end
         end
         LOAD: begin
            byte_ready = 1'b1;
            busy       = 1'b1;
            if (hs && (bcnt == 2'd3)) begin
               state_nx = WRITE;
            end
         end
         WRITE: begin
            we       = 1'b1;
            busy     = 1'b1;
            state_nx = last_word ? DONE : LOAD;
         end
         default: state_nx = IDLE;
      endcase
   end

   assign cpu_stall = busy;

   // Bytes 0..2 collect in asm_q so wdata only changes when a full word is ready.
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
         wcnt  <= '0;
         bcnt  <= '0;
         asm_q <= '0;
         waddr <= '0;
         wdata <= '0;
         done  <= 1'b0;
         err   <= 1'b0;
      end else begin
         unique case (state)
            IDLE, DONE: begin
               if (start_ok) begin
                  bcnt  <= '0;
                  wcnt  <= '0;
                  waddr <= '0;
                  if (n_big) begin
                     err  <= 1'b1;
                     done <= 1'b0;
                  end else if (n_zero) begin
                     err  <= 1'b0;
                     done <= 1'b1;
                  end else begin
                     count <= num_words;
                     err   <= 1'b0;
                     done  <= 1'b0;
                  end
               end
            end
            LOAD: begin
               if (hs) begin
                  bcnt <= bcnt + 2'd1;
                  unique case (bcnt)
                     2'd0: asm_q[7:0]   <= byte_in;
                     2'd1: asm_q[15:8]  <= byte_in;
                     2'd2: asm_q[23:16] <= byte_in;
                     default: wdata     <= {byte_in, asm_q};
                  endcase
               end
            end
            WRITE: begin
               waddr <= waddr + ADDR_ONE;
               wcnt  <= wcnt + CNT_ONE;
               if (last_word) begin
                  done <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: expected imem writes go into a queue and a
// negedge monitor pops and compares every we pulse.
module tb_imem_loader;

   localparam int unsigned DEPTH  = 32;
   localparam int unsigned ADDR_W = 5;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              start = 1'b0;
   logic [ADDR_W:0]   num_words = '0;
   logic [7:0]        byte_in = '0;
   logic              byte_valid = 1'b0;
   logic              byte_ready;
   logic              we;
   logic [ADDR_W-1:0] waddr;
   logic [31:0]       wdata;
   logic              busy;
   logic              cpu_stall;
   logic              done;
   logic              err;

   typedef struct packed {
      logic [ADDR_W-1:0] a;
      logic [31:0]       d;
   } wr_t;

   wr_t exp_q[$];
   int  checks   = 0;
   int  failures = 0;
   bit  mon_en   = 1'b0;

   imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .num_words  (num_words),
      .byte_in    (byte_in),
      .byte_valid (byte_valid),
      .byte_ready (byte_ready),
      .we         (we),
      .waddr      (waddr),
      .wdata      (wdata),
      .busy       (busy),
      .cpu_stall  (cpu_stall),
      .done       (done),
      .err        (err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         if (we === 1'b1) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_we", 32'(we), 32'd0);
            end else begin
               wr_t e;
               e = exp_q.pop_front();
               chk("waddr", 32'(waddr), 32'(e.a));
               chk("wdata", wdata, e.d);
            end
         end
         if (cpu_stall !== busy) chk("cpu_stall_eq_busy", 32'(cpu_stall), 32'(busy));
      end
   end

   task automatic tick(input int unsigned n);
      for (int unsigned i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_start(input int unsigned n);
      start     = 1'b1;
      num_words = (ADDR_W + 1)'(n);
      tick(1);
      start     = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      int unsigned n = 0;
      byte_in    = b;
      byte_valid = 1'b1;
      while (!byte_ready && n < 200) begin
         tick(1);
         n++;
      end
      if (!byte_ready) begin
         chk("handshake_timeout", 32'(byte_ready), 32'd1);
         byte_valid = 1'b0;
         return;
      end
      tick(1);
      byte_valid = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w, input int unsigned gap);
      for (int unsigned k = 0; k < 4; k++) begin
         logic [31:0] t;
         t = w >> (8 * k);
         send_byte(t[7:0]);
         if (gap != 0 && k < 3) begin
            tick(gap + k);
            chk("busy_in_gap", 32'(busy), 32'd1);
            chk("ready_in_gap", 32'(byte_ready), 32'd1);
         end
      end
   endtask

   task automatic expect_wr(input int unsigned a, input logic [31:0] d);
      wr_t e;
      e.a = ADDR_W'(a);
      e.d = d;
      exp_q.push_back(e);
   endtask

   task automatic chk_all_zero(input string nm);
      chk({nm, "_outs"}, {25'd0, byte_ready, we, busy, cpu_stall, done, err, 1'b0}, 32'd0);
      chk({nm, "_waddr"}, 32'(waddr), 32'd0);
      chk({nm, "_wdata"}, wdata, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] w3 [3];
      w3[0] = 32'hDEADBEEF;
      w3[1] = 32'h0BADF00D;
      w3[2] = 32'hCAFEBABE;

      // 1: reset state, bytes without start are ignored
      tick(2);
      rst = 1'b0;
      mon_en = 1'b1;
      chk_all_zero("reset");
      byte_valid = 1'b1;
      byte_in    = 8'hAA;
      for (int i = 0; i < 4; i++) begin
         tick(1);
         chk("idle_no_ready", 32'(byte_ready), 32'd0);
      end
      byte_valid = 1'b0;

      // 2: single word back-to-back
      do_start(1);
      chk("ready_after_start", 32'(byte_ready), 32'd1);
      chk("stall_after_start", 32'(cpu_stall), 32'd1);
      expect_wr(0, 32'h12345678);
      send_word(32'h12345678, 0);
      chk("we_after_4_bytes", 32'(we), 32'd1);
      tick(1);
      chk("t2_done", 32'(done), 32'd1);
      chk("t2_busy", 32'(busy), 32'd0);

      // 3: three words with valid gaps
      do_start(3);
      chk("t3_done_cleared", 32'(done), 32'd0);
      for (int unsigned i = 0; i < 3; i++) begin
         expect_wr(i, w3[i]);
         send_word(w3[i], i + 1);
         chk("t3_stall_write", 32'(cpu_stall), 32'd1);
      end
      tick(1);
      chk("t3_done", 32'(done), 32'd1);

      // 4: full depth, then over-range and zero counts
      do_start(DEPTH);
      for (int unsigned i = 0; i < DEPTH; i++) begin
         logic [31:0] w;
         w = 32'h03020100 + i * 32'h04040404;
         expect_wr(i, w);
         send_word(w, 0);
      end
      tick(1);
      chk("t4_done", 32'(done), 32'd1);
      chk("t4_waddr_wrap", 32'(waddr), 32'd0);
      do_start(DEPTH + 1);
      chk("t4_err", 32'(err), 32'd1);
      chk("t4_err_done", 32'(done), 32'd0);
      chk("t4_err_busy", 32'(busy), 32'd0);
      tick(3);
      chk("t4_err_sticky", 32'(err), 32'd1);
      do_start(0);
      chk("t4_zero_done", 32'(done), 32'd1);
      chk("t4_zero_err", 32'(err), 32'd0);
      chk("t4_zero_busy", 32'(busy), 32'd0);

      // 5: reset in the middle of the second word
      do_start(2);
      expect_wr(0, 32'h44332211);
      send_word(32'h44332211, 0);
      send_byte(8'h99);
      send_byte(8'h88);
      rst = 1'b1;
      tick(1);
      chk_all_zero("midreset");
      rst = 1'b0;
      tick(1);
      do_start(1);
      expect_wr(0, 32'hA1B2C3D4);
      send_word(32'hA1B2C3D4, 0);
      tick(1);
      chk("t5_done", 32'(done), 32'd1);

      // 6: start during LOAD ignored; start from DONE restarts
      do_start(2);
      expect_wr(0, 32'h01234567);
      expect_wr(1, 32'h89ABCDEF);
      send_byte(8'h67);
      send_byte(8'h45);
      do_start(5);
      chk("t6_ignored_busy", 32'(busy), 32'd1);
      send_byte(8'h23);
      send_byte(8'h01);
      tick(1);
      send_word(32'h89ABCDEF, 0);
      tick(1);
      chk("t6_done_after_2", 32'(done), 32'd1);
      do_start(1);
      chk("t6_restart_done_clr", 32'(done), 32'd0);
      chk("t6_restart_busy", 32'(busy), 32'd1);
      expect_wr(0, 32'h5A5AA5A5);
      send_word(32'h5A5AA5A5, 2);
      tick(3);
      chk("t6_done", 32'(done), 32'd1);

      chk("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
